// File: rtl/if_row_sequencer_if.sv
// Handshake bundle between the IF row sequencer and its environment: config/start,
// IF-buffer and PE handshakes, and the read-address/status outputs.
interface if_row_sequencer_if #(
    parameter int POINTER_SIZE         = 8,
    parameter int FILTER_SIZE_REG_SIZE = 8,
    parameter int STRIDE_SIZE          = 3,
    parameter int ROW_CNT_SIZE         = 8
);
    logic                            start;
    logic [POINTER_SIZE-1:0]         row_len;
    logic [FILTER_SIZE_REG_SIZE-1:0] filter_size;
    logic [STRIDE_SIZE-1:0]          stride;
    logic [ROW_CNT_SIZE-1:0]         num_rows;
    logic                            row_valid;
    logic                            pe_ready;
    logic                            rd_en;
    logic [POINTER_SIZE-1:0]         rd_ptr;
    logic                            win_last;
    logic                            next_row;
    logic                            row_done;
    logic                            busy;
    logic                            done;
    logic                            cfg_err;

    modport master (
        input  start, row_len, filter_size, stride, num_rows, row_valid, pe_ready,
        output rd_en, rd_ptr, win_last, next_row, row_done, busy, done, cfg_err
    );

    modport slave (
        output start, row_len, filter_size, stride, num_rows, row_valid, pe_ready,
        input  rd_en, rd_ptr, win_last, next_row, row_done, busy, done, cfg_err
    );
endinterface

// File: rtl/if_row_sequencer.sv
// IF scratchpad read sequencer: per row, walks sliding windows of filter_size spaced by stride.
// Optional stall counter output enabled by defining IF_ROW_SEQUENCER_STALL_CNT_EN.
module if_row_sequencer #(
    parameter int POINTER_SIZE         = 8,
    parameter int FILTER_SIZE_REG_SIZE = 8,
    parameter int STRIDE_SIZE          = 3,
    parameter int ROW_CNT_SIZE         = 8
) (
    input  logic clk,
    input  logic rst,
    if_row_sequencer_if.master bus
`ifdef IF_ROW_SEQUENCER_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);
    localparam int CW = POINTER_SIZE + 2;
    localparam int FW = POINTER_SIZE + FILTER_SIZE_REG_SIZE;

    typedef enum logic [2:0] {IDLE, WAIT_ROW, READ, ROW_END, DONE} state_t;

    state_t                          state_reg, state_next;
    logic [POINTER_SIZE-1:0]         row_len_reg, row_len_next;
    logic [FILTER_SIZE_REG_SIZE-1:0] filter_size_reg, filter_size_next;
    logic [STRIDE_SIZE-1:0]          stride_reg, stride_next;
    logic [ROW_CNT_SIZE-1:0]         rows_left_reg, rows_left_next;
    logic [POINTER_SIZE-1:0]         win_base_reg, win_base_next;
    logic [FILTER_SIZE_REG_SIZE-1:0] elem_reg, elem_next;
    logic                            cfg_err_reg, cfg_err_next;
    logic                            cfg_bad, elem_last, win_fits, reading, rd_en;

    assign cfg_bad = (bus.filter_size == '0) || (bus.stride == '0) || (bus.num_rows == '0) ||
                     (FW'(bus.filter_size) > FW'(bus.row_len));
    assign elem_last = (elem_reg == filter_size_reg - FILTER_SIZE_REG_SIZE'(1));
    // Extra headroom bits so the next-window bound never wraps near the top of the address space.
    assign win_fits  = (CW'(win_base_reg) + CW'(stride_reg) + CW'(filter_size_reg)) <= CW'(row_len_reg);
    assign reading   = (state_reg == READ);
    assign rd_en     = reading & bus.pe_ready;

    assign bus.rd_en    = rd_en;
    assign bus.rd_ptr   = reading ? (win_base_reg + POINTER_SIZE'(elem_reg)) : '0;
    assign bus.win_last = rd_en & elem_last;
    assign bus.next_row = (state_reg == ROW_END);
    assign bus.row_done = (state_reg == ROW_END);
    assign bus.busy     = (state_reg != IDLE);
    assign bus.done     = (state_reg == DONE);
    assign bus.cfg_err  = cfg_err_reg;

    always_comb begin
        state_next       = state_reg;
        row_len_next     = row_len_reg;
        filter_size_next = filter_size_reg;
        stride_next      = stride_reg;
        rows_left_next   = rows_left_reg;
        win_base_next    = win_base_reg;
        elem_next        = elem_reg;
        cfg_err_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    row_len_next     = bus.row_len;
                    filter_size_next = bus.filter_size;
                    stride_next      = bus.stride;
                    if (cfg_bad) begin
                        cfg_err_next = 1'b1;
                    end else begin
                        rows_left_next = bus.num_rows;
                        state_next     = WAIT_ROW;
                    end
                end
            end
            WAIT_ROW: begin
                if (bus.row_valid) begin
                    win_base_next = '0;
                    elem_next     = '0;
                    state_next    = READ;
                end
            end
            READ: begin
                if (bus.pe_ready) begin
                    if (!elem_last) begin
                        elem_next = elem_reg + FILTER_SIZE_REG_SIZE'(1);
                    end else if (win_fits) begin
                        win_base_next = win_base_reg + POINTER_SIZE'(stride_reg);
                        elem_next     = '0;
                    end else begin
                        state_next = ROW_END;
                    end
                end
            end
            ROW_END: begin
                rows_left_next = rows_left_reg - ROW_CNT_SIZE'(1);
                state_next     = (rows_left_reg == ROW_CNT_SIZE'(1)) ? DONE : WAIT_ROW;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            row_len_reg     <= '0;
            filter_size_reg <= '0;
            stride_reg      <= '0;
            rows_left_reg   <= '0;
            win_base_reg    <= '0;
            elem_reg        <= '0;
            cfg_err_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            row_len_reg     <= row_len_next;
            filter_size_reg <= filter_size_next;
            stride_reg      <= stride_next;
            rows_left_reg   <= rows_left_next;
            win_base_reg    <= win_base_next;
            elem_reg        <= elem_next;
            cfg_err_reg     <= cfg_err_next;
        end
    end

`ifdef IF_ROW_SEQUENCER_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    // Counts PE back-pressure cycles for the current job; saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == IDLE) && bus.start) begin
            stall_cnt_reg <= '0;
        end else if (reading && !bus.pe_ready && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_if_row_sequencer.sv
// Self-checking bench for if_row_sequencer: directed scenarios plus randomized jobs,
// all read addresses checked against a window-arithmetic reference model.
module tb_if_row_sequencer;
    localparam int PS = 8;
    localparam int FS = 8;
    localparam int SS = 3;
    localparam int RS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_row_sequencer_if #(.POINTER_SIZE(PS), .FILTER_SIZE_REG_SIZE(FS),
                          .STRIDE_SIZE(SS), .ROW_CNT_SIZE(RS)) bus ();

`ifdef IF_ROW_SEQUENCER_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    if_row_sequencer #(.POINTER_SIZE(PS), .FILTER_SIZE_REG_SIZE(FS),
                       .STRIDE_SIZE(SS), .ROW_CNT_SIZE(RS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
`ifdef IF_ROW_SEQUENCER_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Job configuration as the model sees it (set when a start is issued).
    int cfg_rl, cfg_fs, cfg_st, cfg_nr;
    bit cfg_ok;

    // Observation state owned by the monitor.
    int k = 0, run_rows = 0, per_row = 0;
    int busy_cycles = 0, done_cnt = 0, cfg_err_cnt = 0, row_done_cnt = 0, rd_cnt_total = 0;
    int addr_log[$];
    bit last_log[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Read k of a row: window k/fs, element k%fs within it.
    function automatic int exp_addr(input int kk);
        return (kk / cfg_fs) * cfg_st + (kk % cfg_fs);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            k = 0;
            run_rows = 0;
        end else begin
            if (bus.start && !bus.busy) begin
                k = 0;
                run_rows = 0;
            end
            if (bus.busy) busy_cycles++;
            per_row = cfg_ok ? ((cfg_rl - cfg_fs) / cfg_st + 1) * cfg_fs : 0;
            if (k > 0 && k < per_row) begin
                chk("rd_en_follows_pe_ready", bus.rd_en, bus.pe_ready);
                if (!bus.pe_ready) chk("rd_ptr_hold", bus.rd_ptr, exp_addr(k));
            end
            if (bus.rd_en) begin
                chk("read_within_row", (k < per_row), 1);
                chk("rd_en_needs_pe_ready", bus.pe_ready, 1);
                if (k < per_row) begin
                    chk("rd_ptr", bus.rd_ptr, exp_addr(k));
                    chk("win_last", bus.win_last, ((k % cfg_fs) == cfg_fs - 1));
                end
                addr_log.push_back(int'(bus.rd_ptr));
                last_log.push_back(bus.win_last);
                k++;
                rd_cnt_total++;
            end else if (bus.win_last) begin
                chk("win_last_without_rd_en", bus.win_last, 0);
            end
            if (bus.row_done || bus.next_row) chk("next_row_eq_row_done", bus.next_row, bus.row_done);
            if (bus.row_done) begin
                chk("reads_per_row", k, per_row);
                k = 0;
                run_rows++;
                row_done_cnt++;
            end
            if (bus.done) begin
                chk("rows_before_done", run_rows, cfg_nr);
                done_cnt++;
            end
            if (bus.cfg_err) begin
                chk("cfg_err_expected", bus.cfg_err, !cfg_ok);
                cfg_err_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int rl, input int fs, input int st, input int nr);
        cfg_rl = rl; cfg_fs = fs; cfg_st = st; cfg_nr = nr;
        cfg_ok = !(fs == 0 || st == 0 || nr == 0 || fs > rl);
        bus.row_len = PS'(rl);
        bus.filter_size = FS'(fs);
        bus.stride = SS'(st);
        bus.num_rows = RS'(nr);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("cfg_err_timing", bus.cfg_err, !cfg_ok);
        chk("busy_after_start", bus.busy, cfg_ok);
        // Config must be latched; scramble the live inputs.
        bus.row_len = PS'($urandom);
        bus.filter_size = FS'($urandom);
        bus.stride = SS'($urandom);
        bus.num_rows = RS'($urandom);
    endtask

    task automatic run_until_done(input int budget, input bit rnd);
        int d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) begin
            if (rnd) begin
                bus.pe_ready = ($urandom_range(0, 3) != 0);
                bus.row_valid = ($urandom_range(0, 2) != 0);
                bus.start = ($urandom_range(0, 15) == 0);
                bus.filter_size = FS'($urandom_range(0, 4));
                bus.num_rows = RS'($urandom_range(0, 2));
            end
            step();
        end
        bus.start = 1'b0;
        chk("done_reached", done_cnt - d0, 1);
    endtask

    task automatic chk_seq9(input int a0);
        int ref9[9] = '{0, 1, 2, 2, 3, 4, 4, 5, 6};
        chk("seq9_count", addr_log.size() - a0, 9);
        for (int i = 0; i < 9 && a0 + i < addr_log.size(); i++) begin
            chk("seq9_addr", addr_log[a0 + i], ref9[i]);
            chk("seq9_last", last_log[a0 + i], (i % 3 == 2));
        end
    endtask

    initial begin
        int a0, b0, r0, rd0, e0, dn0;
        bit found;
        bus.start = 0; bus.row_len = 0; bus.filter_size = 0; bus.stride = 0;
        bus.num_rows = 0; bus.row_valid = 0; bus.pe_ready = 0;
        cfg_rl = 0; cfg_fs = 1; cfg_st = 1; cfg_nr = 0; cfg_ok = 0;

        repeat (3) step();
        chk("reset_busy", bus.busy, 0);
        chk("reset_rd_en", bus.rd_en, 0);
        chk("reset_rd_ptr", bus.rd_ptr, 0);
        chk("reset_win_last", bus.win_last, 0);
        chk("reset_next_row", bus.next_row, 0);
        chk("reset_row_done", bus.row_done, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_cfg_err", bus.cfg_err, 0);
`ifdef IF_ROW_SEQUENCER_STALL_CNT_EN
        chk("reset_stall_cnt", stall_cnt, 0);
`endif
        rst = 1'b0;
        step();

        // Basic single row, no back-pressure.
        bus.row_valid = 1; bus.pe_ready = 1;
        a0 = addr_log.size(); b0 = busy_cycles; rd0 = row_done_cnt;
        do_start(8, 3, 2, 1);
        run_until_done(100, 0);
        chk_seq9(a0);
        chk("t1_busy_cycles", busy_cycles - b0, 12);
        chk("t1_row_done_cnt", row_done_cnt - rd0, 1);
        chk("t1_idle_after", bus.busy, 0);
        $display("test basic: reads=%0d busy_cycles=%0d", addr_log.size() - a0, busy_cycles - b0);
        step();

        // Four-cycle PE stall while element address 1 is presented.
        a0 = addr_log.size(); b0 = busy_cycles; r0 = rd_cnt_total;
        do_start(8, 3, 2, 1);
        for (int i = 0; i < 20 && rd_cnt_total == r0; i++) step();
        chk("t2_first_read_seen", rd_cnt_total - r0, 1);
        bus.pe_ready = 0;
        repeat (4) begin
            @(negedge clk);
            chk("t2_stall_rd_ptr", bus.rd_ptr, 1);
            chk("t2_stall_rd_en", bus.rd_en, 0);
        end
        step();
        bus.pe_ready = 1;
        run_until_done(100, 0);
        chk_seq9(a0);
        chk("t2_busy_cycles", busy_cycles - b0, 16);
`ifdef IF_ROW_SEQUENCER_STALL_CNT_EN
        chk("t2_stall_cnt", stall_cnt, 4);
        step();
        chk("t2_stall_cnt_hold", stall_cnt, 4);
`endif
        $display("test stall: reads=%0d busy_cycles=%0d", addr_log.size() - a0, busy_cycles - b0);
        step();

        // Two rows, IF buffer empty for five cycles in between.
        a0 = addr_log.size(); b0 = busy_cycles; rd0 = row_done_cnt;
        do_start(8, 3, 2, 2);
        for (int i = 0; i < 40 && row_done_cnt == rd0; i++) step();
        chk("t3_first_row_done", row_done_cnt - rd0, 1);
        bus.row_valid = 0;
        repeat (5) step();
        chk("t3_waiting_busy", bus.busy, 1);
        chk("t3_waiting_no_rd", bus.rd_en, 0);
        bus.row_valid = 1;
        run_until_done(100, 0);
        chk("t3_reads", addr_log.size() - a0, 18);
        if (addr_log.size() - a0 >= 10) chk("t3_row2_first_addr", addr_log[a0 + 9], 0);
        chk("t3_row_done_cnt", row_done_cnt - rd0, 2);
        chk("t3_busy_cycles", busy_cycles - b0, 28);
        $display("test two_rows: reads=%0d busy_cycles=%0d", addr_log.size() - a0, busy_cycles - b0);
        step();

        // Rejected configurations.
        e0 = cfg_err_cnt; b0 = busy_cycles; r0 = rd_cnt_total;
        do_start(8, 9, 2, 1); step();
        do_start(8, 3, 0, 1); step();
        do_start(8, 3, 2, 0); step();
        do_start(8, 0, 2, 1); step();
        chk("t4_cfg_err_cnt", cfg_err_cnt - e0, 4);
        chk("t4_busy_cycles", busy_cycles - b0, 0);
        chk("t4_no_reads", rd_cnt_total - r0, 0);
        $display("test cfg_err: pulses=%0d", cfg_err_cnt - e0);

        // filter_size == row_len: one window only.
        a0 = addr_log.size(); b0 = busy_cycles;
        do_start(5, 5, 3, 1);
        run_until_done(100, 0);
        chk("t5_reads", addr_log.size() - a0, 5);
        for (int i = 0; i < 5 && a0 + i < addr_log.size(); i++) begin
            chk("t5_addr", addr_log[a0 + i], i);
            chk("t5_last", last_log[a0 + i], (i == 4));
        end
        chk("t5_busy_cycles", busy_cycles - b0, 8);
        $display("test single_window: reads=%0d busy_cycles=%0d", addr_log.size() - a0, busy_cycles - b0);
        step();

        // Reset mid-row, then a fresh job.
        do_start(8, 3, 2, 1);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            found = bus.rd_en && (bus.rd_ptr == 4);
        end
        chk("t6_reached_ptr4", found, 1);
        rd0 = row_done_cnt; dn0 = done_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_busy_after_rst", bus.busy, 0);
        chk("t6_rd_en_after_rst", bus.rd_en, 0);
        chk("t6_row_done_after_rst", bus.row_done, 0);
        repeat (3) step();
        chk("t6_no_row_done", row_done_cnt - rd0, 0);
        chk("t6_no_done", done_cnt - dn0, 0);
        a0 = addr_log.size();
        do_start(8, 3, 2, 1);
        run_until_done(100, 0);
        chk_seq9(a0);
        $display("test reset_mid_row: fresh reads=%0d", addr_log.size() - a0);
        step();

        // Randomized jobs with random back-pressure, buffer readiness and stray starts.
        for (int run = 0; run < 25; run++) begin
            int rl, fs, st, nr, sel;
            rl = $urandom_range(1, 24);
            fs = $urandom_range(1, rl);
            st = $urandom_range(1, 7);
            nr = $urandom_range(1, 3);
            sel = $urandom_range(0, 7);
            if (sel == 0) fs = rl + 1;
            if (sel == 1) nr = 0;
            a0 = addr_log.size(); e0 = cfg_err_cnt;
            bus.pe_ready = 1; bus.row_valid = 1;
            do_start(rl, fs, st, nr);
            if (cfg_ok) begin
                run_until_done(4000, 1);
                chk("rand_total_reads", addr_log.size() - a0, nr * ((rl - fs) / st + 1) * fs);
            end else begin
                step();
                chk("rand_cfg_err", cfg_err_cnt - e0, 1);
            end
            $display("run %0d: rl=%0d fs=%0d st=%0d rows=%0d ok=%0d reads=%0d",
                     run, rl, fs, st, nr, cfg_ok, addr_log.size() - a0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
